// File: rtl/dm_access_ctrl.sv
// Data-memory load/store access controller: builds BRAM byte-enables and write data, flags address
// exceptions, and extends/holds the synchronous BRAM read result for one outstanding load.
module dm_access_ctrl #(
  parameter int unsigned DM_BYTES = 8192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_type,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        stall,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  input  logic [31:0] dm_rd,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        exc_adel,
  output logic        exc_ades
);

  typedef enum logic [1:0] {StIdle, StResp, StHold} state_e;

  state_e      state_q, state_d;
  logic [1:0]  type_q, type_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] hold_q, hold_d;

  logic        misaligned, out_of_range, addr_bad;
  logic        load_accept;
  logic [3:0]  be_raw;
  logic [31:0] wd_raw;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] ext_rdata;

  // Request side: purely combinational, everything forced to zero without a valid request.
  always_comb begin
    misaligned   = (req_type == 2'b01 && req_addr[0]) ||
                   (req_type == 2'b00 && req_addr[1:0] != 2'b00) ||
                   (req_type == 2'b11);
    out_of_range = req_addr >= 32'(DM_BYTES);
    addr_bad     = misaligned || out_of_range;

    be_raw = 4'b0000;
    wd_raw = 32'h0;
    case (req_type)
      2'b00: begin
        be_raw = 4'b1111;
        wd_raw = req_wdata;
      end
      2'b01: begin
        be_raw = req_addr[1] ? 4'b1100 : 4'b0011;
        wd_raw = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        be_raw = 4'b0001 << req_addr[1:0];
        wd_raw = {4{req_wdata[7:0]}};
      end
      default: ;
    endcase

    exc_adel    = req_valid && !req_we && addr_bad;
    exc_ades    = req_valid && req_we && addr_bad;
    dm_we       = req_valid && req_we && !exc_ades && !stall;
    dm_be       = req_valid ? be_raw : 4'b0000;
    dm_wd       = req_valid ? wd_raw : 32'h0;
    dm_addr     = req_valid ? {req_addr[31:2], 2'b00} : 32'h0;
    load_accept = req_valid && !req_we && !exc_adel && !stall;
  end

  // Extend the BRAM word using the attributes of the load that issued it.
  always_comb begin
    half_sel = off_q[1] ? dm_rd[31:16] : dm_rd[15:0];
    case (off_q)
      2'b00:   byte_sel = dm_rd[7:0];
      2'b01:   byte_sel = dm_rd[15:8];
      2'b10:   byte_sel = dm_rd[23:16];
      default: byte_sel = dm_rd[31:24];
    endcase
    case (type_q)
      2'b00:   ext_rdata = dm_rd;
      2'b01:   ext_rdata = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      2'b10:   ext_rdata = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      default: ext_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      type_q  <= 2'b00;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      hold_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    uns_d   = uns_q;
    off_d   = off_q;
    hold_d  = hold_q;
    if (load_accept) begin
      type_d = req_type;
      uns_d  = req_unsigned;
      off_d  = req_addr[1:0];
    end
    unique case (state_q)
      StIdle: if (load_accept) state_d = StResp;
      StResp: begin
        if (stall) begin
          // dm_rd is only valid for this one cycle, so freeze the extended word now.
          hold_d  = ext_rdata;
          state_d = StHold;
        end else begin
          state_d = load_accept ? StResp : StIdle;
        end
      end
      StHold: if (!stall) state_d = load_accept ? StResp : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rsp_valid = 1'b0;
    rsp_rdata = 32'h0;
    unique case (state_q)
      StResp: begin
        rsp_valid = 1'b1;
        rsp_rdata = ext_rdata;
      end
      StHold: begin
        rsp_valid = 1'b1;
        rsp_rdata = hold_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/dm_access_ctrl.md
# dm_access_ctrl

Load/store access controller sitting directly upstream of the data-memory BRAM wrapper in the MEM stage. Converts MEM-stage requests (word/half/byte, signed/unsigned) into BRAM byte-enables, replicated write data and word addresses. Because the BRAM read is synchronous (one-cycle latency), it tracks each outstanding load and extends the returned word in the following cycle. It holds that result across pipeline stalls and flags address exceptions.

## Interface
- DM_BYTES, 8192: data-memory size in bytes; any address >= DM_BYTES is out of range.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM-stage memory request present.
- req_we  in  1  1 = store, 0 = load.
- req_type  in  2  00 word, 01 half, 10 byte, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- stall  in  1  downstream pipeline stall; request and response are held.
- dm_we  out  1  BRAM write enable.
- dm_be  out  4  BRAM byte enables; bit i = byte lane i (little-endian).
- dm_addr  out  32  {req_addr[31:2], 2'b00}.
- dm_wd  out  32  lane-replicated write data.
- dm_rd  in  32  BRAM read word, valid one cycle after the address.
- rsp_valid  out  1  load result available.
- rsp_rdata  out  32  extended load result.
- exc_adel  out  1  load address exception.
- exc_ades  out  1  store address exception.

## Operation
- Request side (combinational, all outputs 0 when req_valid=0):
  - misaligned = (type 01 & addr[0]) | (type 00 & addr[1:0]≠0) | type 11.
  - range = addr >= DM_BYTES.
  - exc_adel = req_valid & ~req_we & (misaligned | range).
  - exc_ades = req_valid & req_we & (misaligned | range).
  - dm_be:
    - word → 1111.
    - half → 0011 << addr[1]*2.
    - byte → 0001 << addr[1:0].
  - dm_wd:
    - word → wdata.
    - half → {2{wdata[15:0]}}.
    - byte → {4{wdata[7:0]}}.
  - dm_we = req_valid & req_we & ~exc_ades & ~stall. A store writes exactly once, in its non-stalled cycle.
- Load accept: req_valid & ~req_we & ~exc_adel & ~stall at a rising edge. The block registers type, unsigned and addr[1:0] into pending regs.
- Response extension of dm_rd, using the pending regs:
  - Select the byte at offset*8, or the half at offset[1]*16.
  - Sign- or zero-extend to 32; word passes through.
- FSM:
  - IDLE:
    - rsp_valid=0.
    - Load accept → RESP.
  - RESP:
    - rsp_valid=1, rsp_rdata=extend(dm_rd).
    - stall → capture extend(dm_rd) into hold, go to HOLD.
    - ~stall & load accept → RESP.
    - Otherwise → IDLE.
  - HOLD:
    - rsp_valid=1, rsp_rdata=hold.
    - stall → HOLD.
    - ~stall & load accept → RESP.
    - ~stall otherwise → IDLE.
- A response is consumed at the first rising edge where rsp_valid=1 and stall=0.
- No load is accepted while stall=1, so at most one response is outstanding.
- rsp_rdata=0 in IDLE.

## Timing
- Reset (async assert, sync-released use):
  - FSM=IDLE.
  - Pending regs and hold cleared to 0.
  - rsp_valid=0, rsp_rdata=0.
  - Combinational outputs follow the request inputs.
- Load accepted at edge N → rsp_valid=1 with data through cycle N+1.
- Back-to-back loads every cycle give one response per cycle.
- Stall asserted during a RESP cycle: the response is frozen from the next cycle onward. dm_rd changes while stalled never affect rsp_rdata.
- Store followed immediately by a load to the same word: the load returns the new data. The BRAM is write-first, and the store commits at the edge before the read.
- Exception cycles produce no BRAM write and no response. The exception flags are combinational, valid in the request cycle.
- Reset asserted in RESP or HOLD: the response is discarded immediately (rsp_valid→0 asynchronously).
- Simultaneous load request and stall: no accept. dm_addr is still driven, which is harmless.

## Test plan
- Byte store: sb, addr 0x5, wdata 0x000000AB → dm_be=0010, dm_wd=0xABABABAB, dm_we=1, dm_addr=0x4. Same request with stall=1 → dm_we=0.
- Signed and unsigned byte loads: mem[0x4]=0x80FF1234.
  - lb 0x7 → next cycle rsp_valid=1, rsp_rdata=0xFFFFFF80.
  - lbu 0x7 → 0x00000080.
  - lh 0x6 → 0xFFFF80FF.
  - lhu 0x4 → 0x00001234.
- Exceptions:
  - lh 0x3 → exc_adel=1, no rsp_valid next cycle.
  - sw 0x2000 (DM_BYTES=8192) → exc_ades=1, dm_we=0.
  - req_type=11 → exception flagged.
- Stall hold: lw 0x8 (mem=0xDEADBEEF), then stall=1 for 3 cycles while dm_rd changes → rsp_rdata stays 0xDEADBEEF and rsp_valid=1 throughout. After stall drops, the next load response arrives normally.
- Back-to-back: lw 0x0, lw 0x4, sw 0x8, lw 0x8 on consecutive cycles → responses in cycles 2, 3 and 5. The load at 0x8 returns the stored value.
- Reset mid-response: assert reset during RESP or HOLD → rsp_valid=0 and rsp_rdata=0 immediately. After release, FSM is in IDLE.
